avalon_mem_arbiter: RTL and testbench
=====================================

Name: avalon_mem_arbiter

Overview:
- Two-master, one-slave Avalon-MM arbiter placed between masters and the shared RAM.
- Master 0 is the CPU bus port of top_level_CPU. Master 1 is a test/boot loader or debug master.
- Masters time-share the slave under round-robin arbitration.
- The non-granted master is stalled through its waitrequest, so both masters keep standard Avalon stall semantics.

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- FIRST_PRIO, 0, master that wins the first tie after reset (0 or 1).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- m0_address  input  ADDR_W  master 0 address.
- m0_read  input  1  master 0 read request.
- m0_write  input  1  master 0 write request.
- m0_writedata  input  DATA_W  master 0 write data.
- m0_byteenable  input  DATA_W/8  master 0 byte lanes.
- m0_readdata  output  DATA_W  master 0 read data.
- m0_waitrequest  output  1  master 0 stall.
- m1_address, m1_read, m1_write, m1_writedata, m1_byteenable, m1_readdata, m1_waitrequest: same as the m0_* set, for master 1.
- s_address  output  ADDR_W  to slave.
- s_read  output  1  to slave.
- s_write  output  1  to slave.
- s_writedata  output  DATA_W  to slave.
- s_byteenable  output  DATA_W/8  to slave.
- s_readdata  input  DATA_W  from slave.
- s_waitrequest  input  1  from slave.
- grant  output  2  one-hot current owner (debug).

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; last_grant = 1-FIRST_PRIO.
  - s_read=s_write=0; s_address/s_writedata/s_byteenable=0; grant=00.
  - m0_waitrequest=m1_waitrequest=1; m*_readdata=0.
- A request is mx_read|mx_write. Both asserted together is illegal; the bench flags it and RTL treats it as a read.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one master requesting: go to its GNT state.
  - Both requesting: grant the master that is not last_grant, then update last_grant on entry.
  - In IDLE, slave read/write are 0 and both waitrequests are 1.
- GNTx:
  - s_* request signals are combinationally driven from master x.
  - mx_waitrequest = s_waitrequest; mx_readdata = s_readdata.
  - The other master sees waitrequest=1 and readdata=0.
  - The transfer completes in the cycle where the request is high and s_waitrequest=0. Next state is IDLE.
  - If master x drops its request while granted (abort), return to IDLE with no transfer counted.
- Latency:
  - 1 arbitration cycle (IDLE) plus the slave latency.
  - Minimum 2 cycles per transfer. A master holding its request continuously gets at most every other slot while the other master is also requesting.
- Fairness: with both masters continuously requesting, grants strictly alternate 0,1,0,1...
- Registered outputs: grant and state only. Datapath muxing is combinational from state, so there is no extra data latency.
- Reset mid-transfer:
  - s_read/s_write fall asynchronously.
  - The in-flight transfer is lost; the master sees waitrequest=1 until it is re-granted.

Optional Feature:
- Macro ARB_LOCK_EN adds input m1_lock (1 bit).
- With the macro:
  - While in GNT1 with m1_lock=1, completion returns directly to GNT1 (no IDLE bubble, no rearbitration). This gives the loader back-to-back bursts.
  - When m1_lock drops, normal completion returns to IDLE.
  - m0 starves only while m1_lock is held.
- Without the macro: the port is absent and behaviour is purely round-robin as above.

Decomposition:
- Shared package avalon_pkg holds:
  - state enum arb_state_t {IDLE, GNT0, GNT1}.
  - localparams for default ADDR_W/DATA_W.
  - a packed struct avalon_req_t {address, read, write, writedata, byteenable}.
- One sub-module is natural: avalon_req_mux, a combinational 2:1 request/response steering block selected by grant. The FSM stays in avalon_mem_arbiter.

Test Plan:
- Only m0 reads addr 0x04; slave waitrequest low after 1 cycle; readdata 0x240A0014 -> grant=01 in the cycle after the request, m0_readdata=0x240A0014 on completion, m1_waitrequest=1 throughout.
- m0 and m1 request simultaneously (m0 read 0x08, m1 write 0x0C data 0x24020040) with FIRST_PRIO=0 -> m0 is served first, then IDLE, then m1. Slave sees write 0x24020040 at 0x0C with byteenable 1111.
- Both masters hold requests for 8 transfers -> grant sequence 01,10,01,10...; each master completes exactly 4 transfers.
- Assert reset low mid-GNT1 write with the slave stalling -> s_write=0 immediately, grant=00, both waitrequests=1. After reset is released, a pending m1 request is re-granted.
- Slave holds waitrequest for 5 cycles during an m0 read while m1 requests -> m1_waitrequest stays 1 throughout; m1 is granted only after m0 completes plus 1 IDLE cycle.
- ARB_LOCK_EN defined, m1_lock=1, m1 issues 3 writes while m0 requests -> the 3 writes go back-to-back with no IDLE cycle. m0 is granted after m1_lock falls.

Source files
------------

// File: rtl/avalon_pkg.sv
// Shared types for the two-master Avalon-MM arbiter: FSM state encoding,
// default bus widths and a request bundle.
package avalon_pkg;

  localparam int AV_ADDR_W = 32;
  localparam int AV_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [AV_ADDR_W-1:0]   address;
    logic                   read;
    logic                   write;
    logic [AV_DATA_W-1:0]   writedata;
    logic [AV_DATA_W/8-1:0] byteenable;
  } avalon_req_t;

endpackage

// File: rtl/avalon_req_mux.sv
// Combinational request/response steering between two Avalon masters and
// one slave, selected by the one-hot grant of the arbiter.
module avalon_req_mux #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [1:0]          grant,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_waitrequest
);

  // A master raising read and write together is served as a read.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_readdata    = '0;
    m1_readdata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    if (grant[0]) begin
      s_address      = m0_address;
      s_read         = m0_read;
      s_write        = m0_write & ~m0_read;
      s_writedata    = m0_writedata;
      s_byteenable   = m0_byteenable;
      m0_readdata    = s_readdata;
      m0_waitrequest = s_waitrequest;
    end else if (grant[1]) begin
      s_address      = m1_address;
      s_read         = m1_read;
      s_write        = m1_write & ~m1_read;
      s_writedata    = m1_writedata;
      s_byteenable   = m1_byteenable;
      m1_readdata    = s_readdata;
      m1_waitrequest = s_waitrequest;
    end
  end

endmodule

// File: rtl/avalon_mem_arbiter.sv
// Round-robin two-master Avalon-MM arbiter in front of a shared RAM.
// Optional ARB_LOCK_EN adds m1_lock for back-to-back master-1 bursts.
module avalon_mem_arbiter
  import avalon_pkg::*;
#(
  parameter int ADDR_W     = AV_ADDR_W,
  parameter int DATA_W     = AV_DATA_W,
  parameter int FIRST_PRIO = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_waitrequest,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
`ifdef ARB_LOCK_EN
  input  logic                m1_lock,
`endif
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_waitrequest,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_read,
  output logic                s_write,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic [DATA_W-1:0]   s_readdata,
  input  logic                s_waitrequest,
  output logic [1:0]          grant
);

  // state | meaning
  // IDLE  | arbitration slot, slave idle, both masters stalled
  // GNT0  | master 0 owns the slave until completion or abort
  // GNT1  | master 1 owns the slave (held across completions while locked)

  arb_state_t state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic [1:0] grant_nxt;
  logic       req0, req1, lock;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef ARB_LOCK_EN
  assign lock = m1_lock;
`else
  assign lock = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= (FIRST_PRIO == 0);
      grant      <= 2'b00;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant      <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last_grant ? GNT0 : GNT1;
        else if (req0)     state_nxt = GNT0;
        else if (req1)     state_nxt = GNT1;
      end
      GNT0: begin
        if (!req0 || !s_waitrequest) state_nxt = IDLE;
      end
      GNT1: begin
        if (!req1)               state_nxt = IDLE;
        else if (!s_waitrequest) state_nxt = lock ? GNT1 : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // grant mirrors the next state so it is registered alongside it
  always_comb begin
    grant_nxt      = 2'b00;
    last_grant_nxt = last_grant;
    case (state_nxt)
      GNT0:    grant_nxt = 2'b01;
      GNT1:    grant_nxt = 2'b10;
      default: grant_nxt = 2'b00;
    endcase
    if (state == IDLE && state_nxt == GNT0) last_grant_nxt = 1'b0;
    if (state == IDLE && state_nxt == GNT1) last_grant_nxt = 1'b1;
  end

  avalon_req_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mux (
    .grant          (grant),
    .m0_address     (m0_address),
    .m0_read        (m0_read),
    .m0_write       (m0_write),
    .m0_writedata   (m0_writedata),
    .m0_byteenable  (m0_byteenable),
    .m0_readdata    (m0_readdata),
    .m0_waitrequest (m0_waitrequest),
    .m1_address     (m1_address),
    .m1_read        (m1_read),
    .m1_write       (m1_write),
    .m1_writedata   (m1_writedata),
    .m1_byteenable  (m1_byteenable),
    .m1_readdata    (m1_readdata),
    .m1_waitrequest (m1_waitrequest),
    .s_address      (s_address),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_writedata    (s_writedata),
    .s_byteenable   (s_byteenable),
    .s_readdata     (s_readdata),
    .s_waitrequest  (s_waitrequest)
  );

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Self-checking bench for avalon_mem_arbiter: directed scenarios followed by
// randomized traffic against a transfer-level round-robin reference model.
module tb_avalon_mem_arbiter;
  import avalon_pkg::*;

  localparam int FP = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] s_address, s_writedata;
  logic        s_read, s_write;
  logic [3:0]  s_byteenable;
  logic [31:0] s_readdata = '0;
  logic        s_waitrequest = 1'b0;
  logic [1:0]  grant;
`ifdef ARB_LOCK_EN
  logic        m1_lock = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  avalon_req_t tr [2];
  bit          pend [2];
  int          owner;
  int          last_m;
  int          done_cnt [2];
  int          seq [$];
  logic [31:0] ref_mem [16];
  logic [31:0] slave_mem [16];

  always #5 clk = ~clk;

  avalon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIRST_PRIO(FP)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
`ifdef ARB_LOCK_EN
    .m1_lock(m1_lock),
`endif
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
    .grant(grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = '0; m1_address = '0;
    s_waitrequest = 0; s_readdata = '0;
`ifdef ARB_LOCK_EN
    m1_lock = 0;
`endif
    reset = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    owner = -1; last_m = 1 - FP; pend[0] = 0; pend[1] = 0;
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    for (int b = 0; b < 4; b++) if (be[b]) old[b*8 +: 8] = d[b*8 +: 8];
    return old;
  endfunction

  function automatic avalon_req_t rand_tr();
    avalon_req_t t;
    t.address    = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    t.read       = 1'($urandom_range(0, 1));
    t.write      = ~t.read;
    t.writedata  = $urandom;
    t.byteenable = 4'($urandom_range(1, 15));
    return t;
  endfunction

  task automatic drive_masters();
    m0_address = tr[0].address; m0_writedata = tr[0].writedata; m0_byteenable = tr[0].byteenable;
    m0_read = pend[0] & tr[0].read; m0_write = pend[0] & tr[0].write;
    m1_address = tr[1].address; m1_writedata = tr[1].writedata; m1_byteenable = tr[1].byteenable;
    m1_read = pend[1] & tr[1].read; m1_write = pend[1] & tr[1].write;
  endtask

  // Model: one idle arbitration slot between owners, ties go to the master
  // not served last, the owner keeps the slave until the slave accepts.
  task automatic observe();
    int          eo;
    bit          r0, r1;
    logic [1:0]  eg;
    avalon_req_t t;
    eo = owner; r0 = pend[0]; r1 = pend[1];
    eg = (eo == 0) ? 2'b01 : (eo == 1) ? 2'b10 : 2'b00;
    chk("grant", grant, eg);
    if (eo < 0) begin
      chk("idle_slave", {s_read, s_write, m0_waitrequest, m1_waitrequest}, 4'b0011);
    end else begin
      t = tr[eo];
      chk("slave_req", {s_address, s_read, s_write, s_byteenable},
          {t.address, t.read, t.write, t.byteenable});
      if (t.write) chk("slave_wdata", s_writedata, t.writedata);
      chk("wait_owner", (eo == 0) ? m0_waitrequest : m1_waitrequest, s_waitrequest);
      chk("other_stalled", (eo == 0) ? {m1_waitrequest, m1_readdata} : {m0_waitrequest, m0_readdata},
          {1'b1, 32'd0});
      if (!s_waitrequest) begin
        if (t.read) chk("readdata", (eo == 0) ? m0_readdata : m1_readdata, ref_mem[t.address[5:2]]);
        else ref_mem[t.address[5:2]] = merge(ref_mem[t.address[5:2]], t.writedata, t.byteenable);
        done_cnt[eo]++;
        seq.push_back(eo);
        pend[eo] = 0;
      end
    end
    if (s_write && !s_waitrequest)
      slave_mem[s_address[5:2]] = merge(slave_mem[s_address[5:2]], s_writedata, s_byteenable);
    if (eo < 0) begin
      if (r0 && r1) owner = 1 - last_m;
      else if (r0)  owner = 0;
      else if (r1)  owner = 1;
      if (owner >= 0) last_m = owner;
    end else if (!s_waitrequest) begin
      owner = -1;
    end
  endtask

  task automatic run(input int n_done, input bit sat, input int max_cyc);
    int target;
    target = done_cnt[0] + done_cnt[1] + n_done;
    for (int c = 0; c < max_cyc && (done_cnt[0] + done_cnt[1]) < target; c++) begin
      cyc();
      for (int m = 0; m < 2; m++)
        if (!pend[m] && (sat || $urandom_range(0, 2) != 0)) begin
          pend[m] = 1;
          tr[m] = rand_tr();
        end
      drive_masters();
      s_waitrequest = sat ? 1'b0 : ($urandom_range(0, 2) == 0);
      #1;
      s_readdata = slave_mem[s_address[5:2]];
      @(negedge clk);
      observe();
    end
    chk("run_budget", done_cnt[0] + done_cnt[1], target);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      slave_mem[i] = ref_mem[i];
    end
    #2;
    chk("rst_slave", {s_read, s_write, s_address, s_writedata, s_byteenable}, '0);
    chk("rst_master", {grant, m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata},
        {2'b00, 2'b11, 64'd0});

    // single master read, one slave wait state
    do_reset();
    cyc(); m0_address = 32'h04; m0_read = 1; s_waitrequest = 1;
    @(negedge clk); chk("t1_idle", {grant, m0_waitrequest, s_read}, {2'b00, 1'b1, 1'b0});
    cyc();
    @(negedge clk); chk("t1_gnt", {grant, s_read, s_address, m0_waitrequest, m1_waitrequest},
                        {2'b01, 1'b1, 32'h04, 1'b1, 1'b1});
    cyc(); s_waitrequest = 0; s_readdata = 32'h240A0014;
    @(negedge clk); chk("t1_done", {m0_waitrequest, m0_readdata, m1_waitrequest},
                        {1'b0, 32'h240A0014, 1'b1});
    cyc(); m0_read = 0; s_waitrequest = 1;
    @(negedge clk); chk("t1_back_idle", {grant, m0_waitrequest, m0_readdata}, {2'b00, 1'b1, 32'd0});

    // simultaneous requests: master 0 wins the first tie
    do_reset();
    cyc(); m0_address = 32'h08; m0_read = 1; s_waitrequest = 0;
    m1_address = 32'h0C; m1_write = 1; m1_writedata = 32'h24020040; m1_byteenable = 4'hF;
    @(negedge clk); chk("t2_idle", grant, 2'b00);
    cyc();
    @(negedge clk); chk("t2_m0", {grant, s_read, s_write, s_address, m0_waitrequest, m1_waitrequest},
                        {2'b01, 2'b10, 32'h08, 2'b01});
    cyc(); m0_read = 0;
    @(negedge clk); chk("t2_gap", {grant, m1_waitrequest}, {2'b00, 1'b1});
    cyc();
    @(negedge clk); chk("t2_m1", {grant, s_write, s_address, s_writedata, s_byteenable, m1_waitrequest, m0_waitrequest},
                        {2'b10, 1'b1, 32'h0C, 32'h24020040, 4'hF, 2'b01});
    cyc(); m1_write = 0;
    @(negedge clk); chk("t2_end", grant, 2'b00);

    // read+write together is illegal; the arbiter must serve it as a read
    do_reset();
    $display("note: m0 drives illegal read+write to observe read priority");
    cyc(); m0_address = 32'h18; m0_read = 1; m0_write = 1;
    cyc();
    @(negedge clk); chk("illegal_as_read", {grant, s_read, s_write}, {2'b01, 2'b10});
    cyc(); m0_read = 0; m0_write = 0;

    // reset while master 1 is stalled mid-write
    do_reset();
    cyc(); m1_address = 32'h10; m1_write = 1; m1_writedata = 32'hCAFE0001; m1_byteenable = 4'hF;
    s_waitrequest = 1;
    cyc();
    @(negedge clk); chk("t4_gnt1", {grant, s_write}, {2'b10, 1'b1});
    #2 reset = 0;
    #1 chk("t4_async", {s_write, grant, m0_waitrequest, m1_waitrequest}, {1'b0, 2'b00, 2'b11});
    cyc(); reset = 1;
    owner = -1; last_m = 1 - FP;
    @(negedge clk); chk("t4_post_idle", {grant, m1_waitrequest}, {2'b00, 1'b1});
    cyc();
    @(negedge clk); chk("t4_regrant", {grant, s_write}, {2'b10, 1'b1});
    cyc(); s_waitrequest = 0;
    cyc(); m1_write = 0;

    // slave stalls master 0 for five cycles while master 1 waits
    do_reset();
    cyc(); m0_address = 32'h08; m0_read = 1; m1_address = 32'h14; m1_read = 1; s_waitrequest = 1;
    @(negedge clk); chk("t5_idle", grant, 2'b00);
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk); chk("t5_stall", {grant, m0_waitrequest, m1_waitrequest}, {2'b01, 2'b11});
    end
    cyc(); s_waitrequest = 0;
    @(negedge clk); chk("t5_m0_done", {grant, m0_waitrequest, m1_waitrequest}, {2'b01, 2'b01});
    cyc(); m0_read = 0; s_waitrequest = 1;
    @(negedge clk); chk("t5_gap", {grant, m1_waitrequest}, {2'b00, 1'b1});
    cyc();
    @(negedge clk); chk("t5_m1", grant, 2'b10);
    cyc(); m1_read = 0;

`ifdef ARB_LOCK_EN
    // locked master 1 burst of three writes while master 0 waits
    do_reset();
    cyc(); m1_lock = 1; m1_write = 1; m1_address = 32'h20; m1_writedata = 32'h1; m1_byteenable = 4'hF;
    @(negedge clk); chk("lk_idle", grant, 2'b00);
    cyc(); m0_read = 1; m0_address = 32'h24;
    @(negedge clk); chk("lk_w1", {grant, s_write, s_address}, {2'b10, 1'b1, 32'h20});
    cyc(); m1_address = 32'h28; m1_writedata = 32'h2;
    @(negedge clk); chk("lk_w2", {grant, s_write, s_address}, {2'b10, 1'b1, 32'h28});
    cyc(); m1_address = 32'h2C; m1_writedata = 32'h3; m1_lock = 0;
    @(negedge clk); chk("lk_w3", {grant, s_write, s_address, m0_waitrequest}, {2'b10, 1'b1, 32'h2C, 1'b1});
    cyc(); m1_write = 0;
    @(negedge clk); chk("lk_gap", grant, 2'b00);
    cyc();
    @(negedge clk); chk("lk_m0", {grant, s_read, s_address}, {2'b01, 1'b1, 32'h24});
    cyc(); m0_read = 0;
`endif

    // saturated traffic: grants strictly alternate
    do_reset();
    seq.delete(); done_cnt[0] = 0; done_cnt[1] = 0;
    run(8, 1'b1, 40);
    chk("sat_count", seq.size(), 8);
    for (int i = 0; i < seq.size(); i++) chk("sat_order", seq[i], i % 2);
    chk("sat_m0", done_cnt[0], 4);
    chk("sat_m1", done_cnt[1], 4);

    // randomized traffic and slave stalls
    do_reset();
    run(60, 1'b0, 800);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
